// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the decryption round tail.
// Holds the forward S-box, used by the inverse key schedule.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  word_t;

  localparam logic [7:0] RCON_POLY = 8'h1B;

  // Forward S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant coefficient this folds to a few XORs.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) acc = acc ^ p;
      p = gf_mul2(p);
    end
    return acc;
  endfunction

  // Rcon one round earlier: inverse of the xtime step, wrapping 0x01 to 0x8D.
  function automatic logic [7:0] rcon_prev(input logic [7:0] r);
    if (r[0]) return ((r ^ RCON_POLY) >> 1) | 8'h80;
    return r >> 1;
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns on one 32-bit column (row 0 in the top byte).
module inv_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);

  logic [7:0] w_a0;
  logic [7:0] w_a1;
  logic [7:0] w_a2;
  logic [7:0] w_a3;

  assign w_a0 = i_col[31:24];
  assign w_a1 = i_col[23:16];
  assign w_a2 = i_col[15:8];
  assign w_a3 = i_col[7:0];

  // Each row rotates the {0E, 0B, 0D, 09} coefficient vector one place right.
  assign o_col[31:24] = gf_mul(w_a0, 8'h0e) ^ gf_mul(w_a1, 8'h0b) ^
                        gf_mul(w_a2, 8'h0d) ^ gf_mul(w_a3, 8'h09);
  assign o_col[23:16] = gf_mul(w_a0, 8'h09) ^ gf_mul(w_a1, 8'h0e) ^
                        gf_mul(w_a2, 8'h0b) ^ gf_mul(w_a3, 8'h0d);
  assign o_col[15:8]  = gf_mul(w_a0, 8'h0d) ^ gf_mul(w_a1, 8'h09) ^
                        gf_mul(w_a2, 8'h0e) ^ gf_mul(w_a3, 8'h0b);
  assign o_col[7:0]   = gf_mul(w_a0, 8'h0b) ^ gf_mul(w_a1, 8'h0d) ^
                        gf_mul(w_a2, 8'h09) ^ gf_mul(w_a3, 8'h0e);

endmodule

// File: rtl/inv_mix_columns_xor.sv
// AES-128 inverse round tail: AddRoundKey then InvMixColumns, plus one backward key-schedule step.
// Optional macro INV_MIX_BYPASS_EN adds bypass_mix to skip InvMixColumns in the final round.
module inv_mix_columns_xor
  import aes_pkg::*;
#(
  parameter int KEY_STAGES = 1
)
(
  input  logic         clock,
  input  logic         reset,
  input  logic         empty_in,
  input  logic         stall,
`ifdef INV_MIX_BYPASS_EN
  input  logic         bypass_mix,
`endif
  input  logic [127:0] state_in,
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon_in,
  output logic [127:0] state_out,
  output logic [127:0] key_out,
  output logic [7:0]   rcon_out,
  output logic         empty
);

  // Valid protocol: empty_in=0 marks the inputs valid; registers load every
  // unstalled cycle regardless, and the empty flag follows the data two stages
  // later. stall=1 freezes everything and the upstream must hold its inputs.

  state_t     r_x;
  logic       r_empty1;
  state_t     r_key1;
  logic [7:0] r_rcon1;
  state_t     r_state_out;
  state_t     r_key_out;
  logic [7:0] r_rcon_out;
  logic       r_empty;

  state_t     w_mixed;
  state_t     w_state_s2;
  state_t     w_key_s1;
  logic [7:0] w_rcon_s1;
  state_t     w_key_s2;
  logic [7:0] w_rcon_s2;

  word_t w_k0;
  word_t w_k1n;
  word_t w_k2n;
  word_t w_k3n;

  genvar c;
  generate
    for (c = 0; c < 4; c++) begin : g_col
      inv_mix_column u_col (
        .i_col (r_x[127 - 32*c -: 32]),
        .o_col (w_mixed[127 - 32*c -: 32])
      );
    end
  endgenerate

`ifdef INV_MIX_BYPASS_EN
  logic r_bypass1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_bypass1 <= 1'b0;
    end else if (!stall) begin
      r_bypass1 <= bypass_mix;
    end
  end

  assign w_state_s2 = r_bypass1 ? r_x : w_mixed;
`else
  assign w_state_s2 = w_mixed;
`endif

  // Words 1..3 of the previous key only need XORs of the current key.
  assign w_k0  = key_in[127:96];
  assign w_k1n = key_in[95:64] ^ key_in[127:96];
  assign w_k2n = key_in[63:32] ^ key_in[95:64];
  assign w_k3n = key_in[31:0]  ^ key_in[63:32];

  // KEY_STAGES=2 splits the S-box step into stage 2; any other value computes it all in stage 1.
  generate
    if (KEY_STAGES == 2) begin : g_key2
      assign w_key_s1  = {w_k0, w_k1n, w_k2n, w_k3n};
      assign w_rcon_s1 = rcon_in;
      assign w_key_s2  = {r_key1[127:96] ^ sub_word(rot_word(r_key1[31:0])) ^ {r_rcon1, 24'h0},
                          r_key1[95:0]};
      assign w_rcon_s2 = rcon_prev(r_rcon1);
    end else begin : g_key1
      assign w_key_s1  = {w_k0 ^ sub_word(rot_word(w_k3n)) ^ {rcon_in, 24'h0},
                          w_k1n, w_k2n, w_k3n};
      assign w_rcon_s1 = rcon_prev(rcon_in);
      assign w_key_s2  = r_key1;
      assign w_rcon_s2 = r_rcon1;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      r_x         <= '0;
      r_empty1    <= 1'b1;
      r_key1      <= '0;
      r_rcon1     <= 8'h00;
      r_state_out <= '0;
      r_key_out   <= '0;
      r_rcon_out  <= 8'h00;
      r_empty     <= 1'b1;
    end else if (!stall) begin
      r_x         <= state_in ^ key_in;
      r_empty1    <= empty_in;
      r_key1      <= w_key_s1;
      r_rcon1     <= w_rcon_s1;
      r_state_out <= w_state_s2;
      r_key_out   <= w_key_s2;
      r_rcon_out  <= w_rcon_s2;
      r_empty     <= r_empty1;
    end
  end

  assign state_out = r_state_out;
  assign key_out   = r_key_out;
  assign rcon_out  = r_rcon_out;
  assign empty     = r_empty;

endmodule

// File: tb/tb_inv_mix_columns_xor.sv
// Directed-vector bench for inv_mix_columns_xor: table vectors, streaming, stall and reset sequences.
`timescale 1ns/1ps
module tb_inv_mix_columns_xor;

  localparam int W = 264;

  typedef struct {
    logic [127:0] s_in;
    logic [127:0] k_in;
    logic [7:0]   r_in;
    logic         byp;
    logic [127:0] s_exp;
    logic [127:0] k_exp;
    logic [7:0]   r_exp;
  } vec_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         empty_in;
  logic         stall;
  logic [127:0] state_in;
  logic [127:0] key_in;
  logic [7:0]   rcon_in;
  logic [127:0] state_out;
  logic [127:0] key_out;
  logic [7:0]   rcon_out;
  logic         empty;
`ifdef INV_MIX_BYPASS_EN
  logic         bypass_mix;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  vec_t vecs[8];
  int   n_vecs;
  logic stall_q = 1'b0;
  logic reset_q = 1'b1;
  logic [13:0] low_mask;
  logic [13:0] exp_mask;

  inv_mix_columns_xor dut (
    .clock      (clock),
    .reset      (reset),
    .empty_in   (empty_in),
    .stall      (stall),
`ifdef INV_MIX_BYPASS_EN
    .bypass_mix (bypass_mix),
`endif
    .state_in   (state_in),
    .key_in     (key_in),
    .rcon_in    (rcon_in),
    .state_out  (state_out),
    .key_out    (key_out),
    .rcon_out   (rcon_out),
    .empty      (empty)
  );

  // clock / reset block
  always #5 clock = ~clock;

  always @(posedge clock) begin
    stall_q <= stall;
    reset_q <= reset;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_vec(input vec_t v, input bit push);
    @(posedge clock);
    #1;
    stall    = 1'b0;
    empty_in = 1'b0;
    state_in = v.s_in;
    key_in   = v.k_in;
    rcon_in  = v.r_in;
`ifdef INV_MIX_BYPASS_EN
    bypass_mix = v.byp;
`endif
    if (push) exp_q.push_back({v.s_exp, v.k_exp, v.r_exp});
  endtask

  task automatic drive_stall(input vec_t v);
    @(posedge clock);
    #1;
    stall    = 1'b1;
    empty_in = 1'b0;
    state_in = v.s_in;
    key_in   = v.k_in;
    rcon_in  = v.r_in;
  endtask

  task automatic drive_idle();
    @(posedge clock);
    #1;
    stall    = 1'b0;
    empty_in = 1'b1;
    state_in = {$urandom, $urandom, $urandom, $urandom};
    key_in   = {$urandom, $urandom, $urandom, $urandom};
    rcon_in  = 8'($urandom_range(0, 255));
  endtask

  // scoreboard: every new valid output is matched against the head of exp_q
  always @(negedge clock) begin
    if (!reset_q && !stall_q && empty === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got state %h with empty=0 expected no valid output", state_out);
      end else begin
        mon_exp = exp_q.pop_front();
        check("state_out", state_out, mon_exp[263:136]);
        check("key_out", key_out, mon_exp[135:8]);
        check("rcon_out", {120'h0, rcon_out}, {120'h0, mon_exp[7:0]});
      end
    end
  end

  initial begin
    reset    = 1'b1;
    empty_in = 1'b1;
    stall    = 1'b0;
    state_in = '0;
    key_in   = '0;
    rcon_in  = 8'h00;
`ifdef INV_MIX_BYPASS_EN
    bypass_mix = 1'b0;
`endif

    vecs[0] = '{{4{32'h8e4da1bc}}, 128'h0, 8'h01, 1'b0, {4{32'hdb135345}},
                128'h62636363_00000000_00000000_00000000, 8'h8d};
    vecs[1] = '{{4{32'h9fdc589d}}, 128'h0, 8'h36, 1'b0, {4{32'hf20a225c}},
                128'h55636363_00000000_00000000_00000000, 8'h1b};
    vecs[2] = '{{4{32'hc6c6c6c6}}, 128'h0, 8'h1b, 1'b0, {4{32'hc6c6c6c6}},
                128'h78636363_00000000_00000000_00000000, 8'h80};
    vecs[3] = '{128'ha0fafe17_88542cb1_23a33939_2a6c7605, 128'ha0fafe17_88542cb1_23a33939_2a6c7605,
                8'h01, 1'b0, 128'h0, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 8'h8d};
    vecs[4] = '{128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6 ^ {4{32'h8e4da1bc}},
                128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6, 8'h36, 1'b0, {4{32'hdb135345}},
                128'hac7766f3_19fadc21_28d12941_575c006e, 8'h1b};
    vecs[5] = '{128'h8e4da1bc_9fdc589d_c6c6c6c6_00000000, 128'h0, 8'h80, 1'b0,
                128'hdb135345_f20a225c_c6c6c6c6_00000000,
                128'he3636363_00000000_00000000_00000000, 8'h40};
    vecs[6] = '{{4{32'h01010101}}, 128'h0, 8'h02, 1'b0, {4{32'h01010101}},
                128'h61636363_00000000_00000000_00000000, 8'h01};
    n_vecs = 7;
`ifdef INV_MIX_BYPASS_EN
    vecs[7] = '{128'h00010203_04050607_08090a0b_0c0d0e0f, 128'h10111213_14151617_18191a1b_1c1d1e1f,
                8'h01, 1'b1, {16{8'h10}},
                128'he3e3e0e1_04040404_0c0c0c0c_04040404, 8'h8d};
    n_vecs = 8;
`endif

    // reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_state", state_out, 128'h0);
    check("rst_key", key_out, 128'h0);
    check("rst_rcon", {120'h0, rcon_out}, 128'h0);
    check("rst_empty", {127'h0, empty}, 128'h1);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // isolated table vectors
    for (int i = 0; i < n_vecs; i++) begin
      drive_vec(vecs[i], 1'b1);
      repeat (3) drive_idle();
    end

    // 10 back-to-back inputs: empty low for exactly 10 cycles from cycle 2
    for (int t = 0; t < 14; t++) begin
      if (t < 10) drive_vec(vecs[t % n_vecs], 1'b1);
      else drive_idle();
      @(negedge clock);
      low_mask[t] = ~empty;
      exp_mask[t] = (t >= 2 && t < 12);
    end
    check("stream_empty_mask", {114'h0, low_mask}, {114'h0, exp_mask});
    repeat (2) drive_idle();

    // stall for 3 edges with two items in flight; inputs during stall must be ignored
    drive_vec(vecs[0], 1'b1);
    drive_vec(vecs[1], 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive_stall(vecs[4]);
      @(negedge clock);
      check("stall_state_frozen", state_out, vecs[0].s_exp);
      check("stall_empty_frozen", {127'h0, empty}, 128'h0);
    end
    drive_vec(vecs[3], 1'b1);
    @(negedge clock);
    check("stall_last_edge", state_out, vecs[0].s_exp);
    repeat (4) drive_idle();

    // reset with two items in flight: second must never emerge
    drive_vec(vecs[2], 1'b1);
    drive_vec(vecs[5], 1'b0);
    @(posedge clock);
    #1;
    reset    = 1'b1;
    empty_in = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("midrst_empty", {127'h0, empty}, 128'h1);
    check("midrst_state", state_out, 128'h0);
    check("midrst_key", key_out, 128'h0);
    check("midrst_rcon", {120'h0, rcon_out}, 128'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("post_rst_empty", {127'h0, empty}, 128'h1);
    end

    repeat (3) drive_idle();
    @(negedge clock);
    check("drain", 128'(exp_q.size()), 128'h0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
